// File: rtl/board_init_sequencer.sv
// board_init_sequencer
//   Board setup controller for the minesweeper datapath. A start request runs
//   three phases in order:
//     1. clear every cell of the mine board,
//     2. hand the mine-board write port to the mine placer and run its
//        start/done/ack handshake,
//     3. sweep the board and write per-cell adjacent-mine counts
//        (0..8, or 4'hF for a mine cell) into the count board.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   start, ack          begin setup (IDLE only) / release from DONE
//   totalMinesIn        requested mine count, clamped and captured on start
//   plStart, plAck      single-cycle pulses to the mine placer
//   plTotalMines        captured mine count to the placer
//   plX, plY,
//   plPlaceMineEn       placer address and write enable
//   plDone              placer finished
//   memX, memY,
//   memWriteEn,
//   memWriteData        mine-board port (muxed between sweeps and placer)
//   memReadData         mine-board read data, combinational on memX/memY
//   cntX, cntY,
//   cntWriteEn,
//   cntWriteData        count-board write port
//   busy, done          status
module board_init_sequencer #(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8,
  localparam int XW = $clog2(boardWidth),
  localparam int YW = $clog2(boardHeight)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ack,
  input  logic [5:0]    totalMinesIn,
  output logic          plStart,
  output logic          plAck,
  output logic [5:0]    plTotalMines,
  input  logic [XW-1:0] plX,
  input  logic [YW-1:0] plY,
  input  logic          plPlaceMineEn,
  input  logic          plDone,
  output logic [XW-1:0] memX,
  output logic [YW-1:0] memY,
  output logic          memWriteEn,
  output logic          memWriteData,
  input  logic          memReadData,
  output logic [XW-1:0] cntX,
  output logic [YW-1:0] cntY,
  output logic          cntWriteEn,
  output logic [3:0]    cntWriteData,
  output logic          busy,
  output logic          done
);

  localparam int CELLS = boardWidth * boardHeight;

  typedef enum logic [2:0] {
    IDLE, CLEAR, PLACE_START, PLACE_WAIT, PLACE_ACK,
    COUNT_READ, COUNT_WRITE, DONE
  } state_t;

  state_t        state;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [1:0]    kx, ky;     // neighbour index k = 3*ky + kx
  logic [3:0]    acc;
  logic          mineFlag;

  // Neighbour coordinate, one bit wider than the cell coordinate. Both
  // underflow (0-1) and overflow (max+1, a power of two) set the top bit, so
  // it alone flags an out-of-range neighbour.
  logic [XW:0]   nxw;
  logic [YW:0]   nyw;
  logic          nxIn, nyIn, centre, addBit, lastCell, lastK;
  logic [XW-1:0] nbX;
  logic [YW-1:0] nbY;
  logic [3:0]    accAdd;
  logic [5:0]    mineCap;

  always_comb begin
    case (kx)
      2'd0:    nxw = {1'b0, cx} - (XW+1)'(1);
      2'd1:    nxw = {1'b0, cx};
      default: nxw = {1'b0, cx} + (XW+1)'(1);
    endcase
    case (ky)
      2'd0:    nyw = {1'b0, cy} - (YW+1)'(1);
      2'd1:    nyw = {1'b0, cy};
      default: nyw = {1'b0, cy} + (YW+1)'(1);
    endcase
    nxIn   = ~nxw[XW];
    nyIn   = ~nyw[YW];
    // An out-of-range neighbour only happens at an edge cell, where the cell
    // coordinate itself is the clamped address.
    nbX    = nxIn ? nxw[XW-1:0] : cx;
    nbY    = nyIn ? nyw[YW-1:0] : cy;
    centre = (kx == 2'd1) && (ky == 2'd1);
    lastK  = (kx == 2'd2) && (ky == 2'd2);
    addBit = nxIn & nyIn & ~centre & memReadData;
    accAdd = acc + {3'b000, addBit};
    lastCell = (cx == XW'(boardWidth - 1)) && (cy == YW'(boardHeight - 1));
    mineCap  = (int'(totalMinesIn) > CELLS - 1) ? 6'(CELLS - 1) : totalMinesIn;
  end

  // Mine-board port mux: own address during CLEAR and COUNT_READ, placer
  // address while the placer owns the board.
  always_comb begin
    memX         = '0;
    memY         = '0;
    memWriteEn   = 1'b0;
    memWriteData = 1'b0;
    case (state)
      CLEAR: begin
        memX       = cx;
        memY       = cy;
        memWriteEn = 1'b1;
      end
      PLACE_WAIT: begin
        memX         = plX;
        memY         = plY;
        memWriteEn   = plPlaceMineEn;
        memWriteData = 1'b1;
      end
      PLACE_ACK: begin
        memX         = plX;
        memY         = plY;
        memWriteData = 1'b1;
      end
      COUNT_READ: begin
        memX = nbX;
        memY = nbY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cx           <= '0;
      cy           <= '0;
      kx           <= '0;
      ky           <= '0;
      acc          <= '0;
      mineFlag     <= 1'b0;
      plStart      <= 1'b0;
      plAck        <= 1'b0;
      plTotalMines <= '0;
      cntX         <= '0;
      cntY         <= '0;
      cntWriteEn   <= 1'b0;
      cntWriteData <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state        <= CLEAR;
          busy         <= 1'b1;
          plTotalMines <= mineCap;
          cx           <= '0;
          cy           <= '0;
          kx           <= '0;
          ky           <= '0;
          acc          <= '0;
          mineFlag     <= 1'b0;
        end

        CLEAR: begin
          cx <= cx + 1'b1;
          if (cx == XW'(boardWidth - 1)) cy <= cy + 1'b1;
          if (lastCell) begin
            // A zero count would make the placer wrap and fill the board.
            if (plTotalMines == '0) state <= COUNT_READ;
            else begin
              state   <= PLACE_START;
              plStart <= 1'b1;
            end
          end
        end

        PLACE_START: begin
          plStart <= 1'b0;
          state   <= PLACE_WAIT;
        end

        PLACE_WAIT: if (plDone) begin
          plAck <= 1'b1;
          state <= PLACE_ACK;
        end

        PLACE_ACK: begin
          plAck <= 1'b0;
          cx    <= '0;
          cy    <= '0;
          kx    <= '0;
          ky    <= '0;
          state <= COUNT_READ;
        end

        COUNT_READ: begin
          if (centre) mineFlag <= memReadData;
          acc <= accAdd;
          if (lastK) begin
            state        <= COUNT_WRITE;
            cntWriteEn   <= 1'b1;
            cntX         <= cx;
            cntY         <= cy;
            // Include the final neighbour's contribution directly.
            cntWriteData <= mineFlag ? 4'hF : accAdd;
            kx           <= '0;
            ky           <= '0;
          end else if (kx == 2'd2) begin
            kx <= '0;
            ky <= ky + 1'b1;
          end else begin
            kx <= kx + 1'b1;
          end
        end

        COUNT_WRITE: begin
          cntWriteEn   <= 1'b0;
          cntWriteData <= '0;
          acc          <= '0;
          mineFlag     <= 1'b0;
          cx           <= cx + 1'b1;
          if (cx == XW'(boardWidth - 1)) cy <= cy + 1'b1;
          if (lastCell) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= COUNT_READ;
          end
        end

        DONE: if (ack) begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_init_sequencer.sv
// Directed bench for board_init_sequencer on an 8x8 board. Models the mine
// and count boards as simple memories and a mine-placer stub that writes a
// list of positions, then raises plDone until plAck.
module tb_board_init_sequencer;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, ack = 1'b0;
  logic [5:0] totalMinesIn = '0;
  logic       plStart, plAck;
  logic [5:0] plTotalMines;
  logic [2:0] plX = '0, plY = '0;
  logic       plPlaceMineEn = 1'b0, plDone = 1'b0;
  logic [2:0] memX, memY, cntX, cntY;
  logic       memWriteEn, memWriteData, memReadData, cntWriteEn;
  logic [3:0] cntWriteData;
  logic       busy, done;

  board_init_sequencer #(.boardWidth(8), .boardHeight(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .totalMinesIn(totalMinesIn), .plStart(plStart), .plAck(plAck),
    .plTotalMines(plTotalMines), .plX(plX), .plY(plY),
    .plPlaceMineEn(plPlaceMineEn), .plDone(plDone),
    .memX(memX), .memY(memY), .memWriteEn(memWriteEn),
    .memWriteData(memWriteData), .memReadData(memReadData),
    .cntX(cntX), .cntY(cntY), .cntWriteEn(cntWriteEn),
    .cntWriteData(cntWriteData), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [63:0] mine;
  logic [3:0]  cnt [64];
  assign memReadData = mine[{memY, memX}];
  always @(posedge clk) begin
    if (memWriteEn) mine[{memY, memX}] <= memWriteData;
    if (cntWriteEn) cnt[{cntY, cntX}] <= cntWriteData;
  end

  int nvec = 0, nbad = 0;
  int nStart, nAck, overlap, nCntWr, nCntNz, clrGood, ackGap, busyBad, seenDone;

  task automatic chk(input string what, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  // Runs one setup from start to done; the placer stub writes pos[0..nm-1].
  // edges = clock edges from the start-sampling edge to done rising.
  task automatic run(input logic [5:0] tm, input int nm,
                     input logic [7:0][5:0] pos, input bit poke,
                     output int edges);
    int sidx, dcyc, acyc;
    nStart = 0; nAck = 0; overlap = 0; nCntWr = 0; nCntNz = 0;
    clrGood = 0; busyBad = 0; seenDone = 0;
    sidx = -1; dcyc = -100; acyc = -200; edges = -1;
    totalMinesIn = tm;
    start = 1'b1;
    for (int cyc = 1; cyc <= 3000 && seenDone == 0; cyc++) begin
      @(negedge clk);
      if (done) begin
        seenDone = 1;
        edges = cyc - 1;
        start = 1'b0;
      end else begin
        if (!busy) busyBad++;
        if (plStart) nStart++;
        if (plAck) begin nAck++; acyc = cyc; end
        if (plStart && plAck) overlap++;
        if (cntWriteEn) begin
          nCntWr++;
          if (cntWriteData != 4'h0) nCntNz++;
        end
        if (cyc <= 64 && memWriteEn && !memWriteData &&
            memX == 3'(cyc - 1) && memY == 3'((cyc - 1) / 8)) clrGood++;
        // stray start pulses: one in PLACE_WAIT, one in COUNT_READ
        start = (poke && (cyc == 67 || cyc == 72 + nm)) ? 1'b1 : 1'b0;
        if (plStart) begin
          sidx = 0;
          plPlaceMineEn = 1'b0;
        end else if (sidx >= 0 && sidx < nm) begin
          plX = pos[sidx][2:0];
          plY = pos[sidx][5:3];
          plPlaceMineEn = 1'b1;
          sidx++;
        end else if (sidx == nm) begin
          plPlaceMineEn = 1'b0;
          plDone = 1'b1;
          dcyc = cyc;
          sidx++;
        end
        if (plAck) plDone = 1'b0;
      end
    end
    ackGap = acyc - dcyc;
    chk("done reached", seenDone, 1);
  endtask

  task automatic release_done();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack clears done", done, 0);
  endtask

  typedef struct {
    logic [5:0]      tm;
    int              nm;
    bit              poke;
    logic [7:0][5:0] pos;   // index 0 is the rightmost element
    logic [3:0][5:0] cpos;  // cell index y*8+x
    logic [3:0][3:0] cval;
  } vec_t;

  vec_t vt [4];

  initial begin
    int edges;
    // (0,0),(1,1) -> (0,0)=F,(1,0)=2,(2,2)=1,(7,7)=0
    vt[0] = '{tm: 6'd2, nm: 2, poke: 1'b0,
              pos:  {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9, 6'd0},
              cpos: {6'd63, 6'd18, 6'd1, 6'd0},
              cval: {4'h0, 4'h1, 4'h2, 4'hF}};
    // ring around (3,3) -> (3,3)=8,(2,2)=F,(1,1)=1,(5,5)=1
    vt[1] = '{tm: 6'd8, nm: 8, poke: 1'b1,
              pos:  {6'd36, 6'd35, 6'd34, 6'd28, 6'd26, 6'd20, 6'd19, 6'd18},
              cpos: {6'd45, 6'd9, 6'd18, 6'd27},
              cval: {4'h1, 4'h1, 4'hF, 4'h8}};
    // (1,0),(0,1),(1,1) -> (0,0)=3,(7,0)=0,(2,0)=2,(0,2)=2
    vt[2] = '{tm: 6'd63, nm: 3, poke: 1'b0,
              pos:  {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9, 6'd8, 6'd1},
              cpos: {6'd16, 6'd2, 6'd7, 6'd0},
              cval: {4'h2, 4'h2, 4'h0, 4'h3}};
    // (6,6),(7,6),(6,7) -> (7,7)=3,(0,0)=0,(5,5)=1,(7,5)=2
    vt[3] = '{tm: 6'd3, nm: 3, poke: 1'b0,
              pos:  {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd62, 6'd55, 6'd54},
              cpos: {6'd47, 6'd45, 6'd0, 6'd63},
              cval: {4'h2, 4'h1, 4'h0, 4'h3}};

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst plStart", plStart, 0);
    chk("rst plAck", plAck, 0);
    chk("rst memWriteEn", memWriteEn, 0);
    chk("rst cntWriteEn", cntWriteEn, 0);
    chk("rst plTotalMines", plTotalMines, 0);
    chk("rst memXY", {memY, memX}, 0);
    reset = 1'b1;
    @(negedge clk);

    // zero mines: no placer, 64 clears, 64 zero counts, 704 cycles
    run(6'd0, 0, '0, 1'b0, edges);
    chk("zero edges", edges, 704);
    chk("zero plStart", nStart, 0);
    chk("zero clear cells", clrGood, 64);
    chk("zero cnt writes", nCntWr, 64);
    chk("zero cnt nonzero", nCntNz, 0);
    chk("zero busy", busyBad, 0);
    release_done();

    for (int i = 0; i < 4; i++) begin
      run(vt[i].tm, vt[i].nm, vt[i].pos, vt[i].poke, edges);
      chk($sformatf("v%0d edges", i), edges, 707 + vt[i].nm);
      chk($sformatf("v%0d plStart pulses", i), nStart, 1);
      chk($sformatf("v%0d plAck pulses", i), nAck, 1);
      chk($sformatf("v%0d ack gap", i), ackGap, 1);
      chk($sformatf("v%0d start/ack overlap", i), overlap, 0);
      chk($sformatf("v%0d clear cells", i), clrGood, 64);
      chk($sformatf("v%0d cnt writes", i), nCntWr, 64);
      chk($sformatf("v%0d plTotalMines", i), plTotalMines, vt[i].tm);
      for (int j = 0; j < 4; j++)
        chk($sformatf("v%0d cell %0d", i, vt[i].cpos[j]),
            cnt[vt[i].cpos[j]], vt[i].cval[j]);
      if (i < 3) release_done();
    end

    // ack and start together in DONE: back to IDLE, start not honoured
    ack = 1'b1; start = 1'b1;
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    chk("ack+start done", done, 0);
    chk("ack+start busy", busy, 0);
    @(negedge clk);
    chk("ack+start stays idle", busy, 0);

    // reset during COUNT_READ of cell 20 (cycles 265..273)
    nCntWr = 0;
    totalMinesIn = 6'd0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 267; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cntWriteEn) nCntWr++;
    end
    chk("pre-reset cnt writes", nCntWr, 20);
    chk("pre-reset busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst memXY", {memY, memX}, 0);
    chk("midrst memWriteEn", memWriteEn, 0);
    chk("midrst cntWriteEn", cntWriteEn, 0);
    run(6'd0, 0, '0, 1'b0, edges);
    chk("restart clear cells", clrGood, 64);
    chk("restart edges", edges, 704);
    release_done();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
